hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, HI/LO busy interlock, branch/jump flushes.
// Emits per-stage PC / IF-ID / ID-EX steering codes and a saturating stall counter.
module hazard_ctrl_unit #(
   parameter int unsigned USE_DELAY_SLOT  = 0,
   parameter int unsigned LU_STALL_CYCLES = 1,
   parameter int unsigned MDU_LATENCY     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IFID_MemWr,
   input  logic [4:0]  IFID_Rs,
   input  logic [4:0]  IFID_Rt,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_Rt,
   input  logic [1:0]  ID_willjump,
   input  logic        EX_willbranch,
   input  logic        ID_mdu_start,
   input  logic        ID_hilo_read,
   output logic [1:0]  PC_choice,
   output logic [1:0]  IFID_choice,
   output logic [1:0]  IDEX_choice,
   output logic        mdu_busy,
   output logic [31:0] stall_count
);

   localparam logic [1:0] ChFlush = 2'b00;
   localparam logic [1:0] ChNorm  = 2'b01;
   localparam logic [1:0] ChKeep  = 2'b10;

   typedef enum logic [0:0] {StRun, StLuWait} state_e;

   state_e      state_q, state_d;
   logic [2:0]  lu_cnt_q, lu_cnt_d;
   logic [5:0]  mdu_cnt_q, mdu_cnt_d;
   logic [31:0] stall_count_q, stall_count_d;
   logic        load_use;
   logic        mdu_hazard;
   logic        stall;

   // r0 is deliberately not exempt; a store only reads Rt as data, so it is excluded.
   assign load_use = IDEX_MemRead &&
                     ((IDEX_Rt == IFID_Rs) || (!IFID_MemWr && (IDEX_Rt == IFID_Rt)));

   assign mdu_busy    = !reset && (mdu_cnt_q != 6'd0);
   assign mdu_hazard  = mdu_busy && (ID_hilo_read || ID_mdu_start);
   assign stall_count = stall_count_q;

   always_comb begin
      PC_choice   = ChNorm;
      IFID_choice = ChNorm;
      IDEX_choice = ChNorm;
      state_d     = state_q;
      lu_cnt_d    = lu_cnt_q;
      stall       = 1'b0;

      if (reset) begin
         IFID_choice = ChFlush;
         IDEX_choice = ChFlush;
         state_d     = StRun;
         lu_cnt_d    = 3'd0;
      end else if (EX_willbranch) begin
         IFID_choice = ChFlush;
         IDEX_choice = ChFlush;
         state_d     = StRun;
         lu_cnt_d    = 3'd0;
      end else if (state_q == StLuWait) begin
         stall    = 1'b1;
         lu_cnt_d = lu_cnt_q - 3'd1;
         if (lu_cnt_q == 3'd1) begin
            state_d = StRun;
         end
      end else if (load_use) begin
         stall = 1'b1;
         if (LU_STALL_CYCLES > 1) begin
            state_d  = StLuWait;
            lu_cnt_d = 3'(LU_STALL_CYCLES - 1);
         end
      end else if (mdu_hazard) begin
         stall = 1'b1;
      end else if ((USE_DELAY_SLOT == 0) && (ID_willjump != 2'b00)) begin
         IFID_choice = ChFlush;
      end

      if (stall) begin
         PC_choice   = ChKeep;
         IFID_choice = ChKeep;
         IDEX_choice = ChFlush;
      end
   end

   // The mult/div only issues if it actually advances into ID/EX this cycle.
   always_comb begin
      mdu_cnt_d = mdu_cnt_q;
      if (ID_mdu_start && (IDEX_choice == ChNorm)) begin
         mdu_cnt_d = 6'(MDU_LATENCY);
      end else if (mdu_cnt_q != 6'd0) begin
         mdu_cnt_d = mdu_cnt_q - 6'd1;
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StRun;
         lu_cnt_q      <= 3'd0;
         mdu_cnt_q     <= 6'd0;
         stall_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         lu_cnt_q      <= lu_cnt_d;
         mdu_cnt_q     <= mdu_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios then random traffic, all checked against a
// cycle-level reference model of remaining bubbles / HI-LO busy time.
module tb_hazard_ctrl_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        IFID_MemWr;
   logic [4:0]  IFID_Rs, IFID_Rt;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_Rt;
   logic [1:0]  ID_willjump;
   logic        EX_willbranch;
   logic        ID_mdu_start;
   logic        ID_hilo_read;

   logic [1:0]  pc0, ifid0, idex0, pc1, ifid1, idex1;
   logic        busy0, busy1;
   logic [31:0] cnt0, cnt1;

   int          n_assert = 0;
   int          n_fail   = 0;

   // Reference model state
   int          m_bubbles_left = 0;   // forced bubbles still owed after the current one
   int          m_mdu_left     = 0;   // cycles HI/LO remain busy
   longint      m_stalls       = 0;
   bit          m_valid        = 1'b0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(
      .USE_DELAY_SLOT (0),
      .LU_STALL_CYCLES(3),
      .MDU_LATENCY    (4)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .IFID_MemWr   (IFID_MemWr),
      .IFID_Rs      (IFID_Rs),
      .IFID_Rt      (IFID_Rt),
      .IDEX_MemRead (IDEX_MemRead),
      .IDEX_Rt      (IDEX_Rt),
      .ID_willjump  (ID_willjump),
      .EX_willbranch(EX_willbranch),
      .ID_mdu_start (ID_mdu_start),
      .ID_hilo_read (ID_hilo_read),
      .PC_choice    (pc0),
      .IFID_choice  (ifid0),
      .IDEX_choice  (idex0),
      .mdu_busy     (busy0),
      .stall_count  (cnt0)
   );

   hazard_ctrl_unit #(
      .USE_DELAY_SLOT (1),
      .LU_STALL_CYCLES(3),
      .MDU_LATENCY    (4)
   ) u_dut_ds (
      .clk          (clk),
      .reset        (reset),
      .IFID_MemWr   (IFID_MemWr),
      .IFID_Rs      (IFID_Rs),
      .IFID_Rt      (IFID_Rt),
      .IDEX_MemRead (IDEX_MemRead),
      .IDEX_Rt      (IDEX_Rt),
      .ID_willjump  (ID_willjump),
      .EX_willbranch(EX_willbranch),
      .ID_mdu_start (ID_mdu_start),
      .ID_hilo_read (ID_hilo_read),
      .PC_choice    (pc1),
      .IFID_choice  (ifid1),
      .IDEX_choice  (idex1),
      .mdu_busy     (busy1),
      .stall_count  (cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reset         = 1'b0;
      IFID_MemWr    = 1'b0;
      IFID_Rs       = 5'd1;
      IFID_Rt       = 5'd2;
      IDEX_MemRead  = 1'b0;
      IDEX_Rt       = 5'd3;
      ID_willjump   = 2'b00;
      EX_willbranch = 1'b0;
      ID_mdu_start  = 1'b0;
      ID_hilo_read  = 1'b0;
   endtask

   // One clock cycle: predict outputs from the model, compare mid-cycle, then advance the model.
   task automatic step(input string tag);
      logic [5:0] exp0, exp1;
      logic       exp_busy;
      bit         hazard_lu, stalled, advance;
      int         nb, nm;
      @(negedge clk);
      nb = m_bubbles_left;
      nm = (m_mdu_left > 0) ? m_mdu_left - 1 : 0;
      stalled = 1'b0;
      if (reset) begin
         exp0 = 6'b01_00_00;
         exp1 = 6'b01_00_00;
         exp_busy = 1'b0;
      end else begin
         exp_busy  = (m_mdu_left > 0);
         hazard_lu = IDEX_MemRead && (IDEX_Rt == IFID_Rs ||
                                      (!IFID_MemWr && IDEX_Rt == IFID_Rt));
         exp0 = 6'b01_01_01;
         exp1 = 6'b01_01_01;
         if (EX_willbranch) begin
            exp0 = 6'b01_00_00;
            exp1 = 6'b01_00_00;
            nb   = 0;
         end else if (m_bubbles_left > 0) begin
            stalled = 1'b1;
            nb      = m_bubbles_left - 1;
         end else if (hazard_lu) begin
            stalled = 1'b1;
            nb      = 3 - 1;
         end else if (exp_busy && (ID_hilo_read || ID_mdu_start)) begin
            stalled = 1'b1;
         end else if (ID_willjump != 2'b00) begin
            exp0 = 6'b01_00_01;
         end
         if (stalled) begin
            exp0 = 6'b10_10_00;
            exp1 = 6'b10_10_00;
         end
         advance = (exp0[1:0] == 2'b01);
         if (ID_mdu_start && advance) nm = 4;
      end
      chk({tag, ":choice"},    {26'd0, pc0, ifid0, idex0}, {26'd0, exp0});
      chk({tag, ":choice_ds"}, {26'd0, pc1, ifid1, idex1}, {26'd0, exp1});
      chk({tag, ":busy"},      {31'd0, busy0},             {31'd0, exp_busy});
      if (m_valid) chk({tag, ":stall_count"}, cnt0, 32'(m_stalls));
      @(posedge clk);
      if (reset) begin
         m_bubbles_left = 0;
         m_mdu_left     = 0;
         m_stalls       = 0;
         m_valid        = 1'b1;
      end else begin
         m_bubbles_left = nb;
         m_mdu_left     = nm;
         if (stalled) m_stalls++;
      end
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd1; EX_willbranch = 1'b1;  // reset must override these
      step("reset0");
      step("reset1");

      // Three-bubble load-use, then free flow
      idle();
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
      step("lu_hit");
      IDEX_MemRead = 1'b0;
      step("lu_wait1");
      step("lu_wait2");
      step("lu_done");
      chk("lu_total_stalls", cnt0, 32'd3);

      // Store data operand does not create a hazard
      idle();
      IFID_MemWr = 1'b1; IFID_Rt = 5'd5; IFID_Rs = 5'd6; IDEX_Rt = 5'd5; IDEX_MemRead = 1'b1;
      step("store_no_stall");

      // Register 0 is not exempt
      idle();
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rt = 5'd0; IFID_Rs = 5'd7;
      step("lu_r0");
      idle();
      step("lu_r0_w1");
      step("lu_r0_w2");

      // Mult issue then mfhi held: four interlock cycles, advances on the fifth
      idle();
      ID_mdu_start = 1'b1;
      step("mdu_issue");
      ID_mdu_start = 1'b0; ID_hilo_read = 1'b1;
      for (int i = 0; i < 5; i++) step($sformatf("mdu_read%0d", i));
      idle();
      step("mdu_idle");

      // Branch during second load-use bubble
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9;
      step("br_lu");
      idle();
      EX_willbranch = 1'b1;
      step("br_in_wait");
      EX_willbranch = 1'b0;
      step("br_after");

      // Jump held across a load-use stall, flushed only once the stall clears
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd4; IFID_Rt = 5'd4; ID_willjump = 2'b01;
      step("jmp_lu");
      IDEX_MemRead = 1'b0;
      step("jmp_wait1");
      step("jmp_wait2");
      step("jmp_flush");
      idle();

      // Reset in the middle of LU_WAIT with HI/LO busy
      ID_mdu_start = 1'b1;
      step("rst_mdu_issue");
      idle();
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
      step("rst_lu");
      idle();
      reset = 1'b1; ID_hilo_read = 1'b1;
      step("rst_pulse");
      reset = 1'b0;
      step("rst_after");
      chk("rst_count_cleared", cnt0, 32'd0);
      idle();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 49) == 0);
         IFID_MemWr    = $urandom_range(0, 1) == 1;
         IFID_Rs       = 5'($urandom_range(0, 3));
         IFID_Rt       = 5'($urandom_range(0, 3));
         IDEX_MemRead  = ($urandom_range(0, 2) == 0);
         IDEX_Rt       = 5'($urandom_range(0, 3));
         ID_willjump   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         EX_willbranch = ($urandom_range(0, 9) == 0);
         ID_mdu_start  = ($urandom_range(0, 5) == 0);
         ID_hilo_read  = ($urandom_range(0, 3) == 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
